dsc_chunk_reader: RTL

DSC_CHUNK_READER -- requirements
Module: dsc_chunk_reader

---
 rtl/dsc_chunk_reader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dsc_chunk_reader.sv
// dsc_chunk_reader
// Packs a compressed DSC byte stream (encoder cmpr_buf order) into 32-bit little-endian
// chunk words. Every slice line is one chunk of (width*bpp+7)>>3 bytes, and each chunk
// starts at lane 0 of a new word.
//
// Optional feature: define DSC_BYTE_CNT_EN to add the byte_cnt output, which counts the
// accepted input bytes.
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   start                one-cycle pulse in IDLE that latches cfg_* and starts one slice
//   cfg_slice_width      pixels per line
//   cfg_slice_height     lines per slice
//   cfg_bpp              integer compressed bits per pixel
//   busy                 high in every state except IDLE
//   err                  one-cycle pulse when the latched configuration has a zero field
//   s_valid/s_ready      compressed byte stream handshake, with s_data carrying the byte
//   m_valid/m_ready      packed word handshake
//   m_data, m_be         word data and contiguous low byte enables
//   m_sol, m_eol, m_eos  first word of chunk, last word of chunk, last word of slice
//   byte_cnt             (DSC_BYTE_CNT_EN only) accepted byte count, wraps at 2^32
module dsc_chunk_reader #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_slice_width,
    input  logic [CNT_W-1:0] cfg_slice_height,
    input  logic [5:0]       cfg_bpp,
    output logic             busy,
    output logic             err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [3:0]       m_be,
    output logic             m_sol,
    output logic             m_eol,
    output logic             m_eos
`ifdef DSC_BYTE_CNT_EN
    ,
    output logic [31:0]      byte_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StCalc, StRun, StDone} state_t;

    localparam logic [CNT_W+6:0] RoundUp  = 7;
    localparam logic [CNT_W+3:0] ChunkOne = 1;
    localparam logic [CNT_W-1:0] LineOne  = 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_height;
    logic [5:0]       r_bpp;
    logic [CNT_W+3:0] r_chunk_bytes;
    logic [CNT_W+3:0] r_chunk_cnt;
    logic [CNT_W-1:0] r_line;
    logic [1:0]       r_lane;
    logic [31:0]      r_acc;
    logic             r_first;
    logic             r_err;
    logic             r_m_valid;
    logic [31:0]      r_m_data;
    logic [3:0]       r_m_be;
    logic             r_m_sol;
    logic             r_m_eol;
    logic             r_m_eos;

    logic [CNT_W+5:0] w_prod;
    logic [CNT_W+6:0] w_sum;
    logic [CNT_W+3:0] w_chunk_bytes;
    logic             w_cfg_zero;
    logic             w_all_in;
    logic             w_accept;
    logic             w_last_byte;
    logic             w_last_line;
    logic [31:0]      w_word;
    logic [3:0]       w_be;

    // Full-precision chunk size: CNT_W+6 bit product, rounded up to whole bytes.
    assign w_prod        = {6'b0, r_width} * {{CNT_W{1'b0}}, r_bpp};
    assign w_sum         = {1'b0, w_prod} + RoundUp;
    assign w_chunk_bytes = w_sum[CNT_W+6:3];
    assign w_cfg_zero    = (r_width == '0) || (r_height == '0) || (r_bpp == '0);

    // Once the last chunk's final byte is in, no further bytes are taken for this slice.
    assign w_all_in    = (r_line == r_height);
    assign s_ready     = (r_state == StRun) && !w_all_in && (!r_m_valid || m_ready);
    assign w_accept    = s_valid && s_ready;
    assign w_last_byte = (r_chunk_cnt == r_chunk_bytes - ChunkOne);
    assign w_last_line = (r_line == r_height - LineOne);

    // Insert the incoming byte into the current lane; lanes above it stay zero.
    always_comb begin
        w_word = r_acc;
        w_be   = 4'h1;
        case (r_lane)
            2'd0: begin w_word[7:0]   = s_data; w_be = 4'h1; end
            2'd1: begin w_word[15:8]  = s_data; w_be = 4'h3; end
            2'd2: begin w_word[23:16] = s_data; w_be = 4'h7; end
            default: begin w_word[31:24] = s_data; w_be = 4'hF; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_width       <= '0;
            r_height      <= '0;
            r_bpp         <= '0;
            r_chunk_bytes <= '0;
            r_chunk_cnt   <= '0;
            r_line        <= '0;
            r_lane        <= '0;
            r_acc         <= '0;
            r_first       <= 1'b0;
            r_err         <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_be        <= '0;
            r_m_sol       <= 1'b0;
            r_m_eol       <= 1'b0;
            r_m_eos       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_width  <= cfg_slice_width;
                        r_height <= cfg_slice_height;
                        r_bpp    <= cfg_bpp;
                        r_state  <= StCalc;
                    end
                end
                StCalc: begin
                    r_chunk_bytes <= w_chunk_bytes;
                    r_chunk_cnt   <= '0;
                    r_line        <= '0;
                    r_lane        <= '0;
                    r_acc         <= '0;
                    r_first       <= 1'b1;
                    if (w_cfg_zero) begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        if ((r_lane == 2'd3) || w_last_byte) begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= w_word;
                            r_m_be    <= w_be;
                            r_m_sol   <= r_first;
                            r_m_eol   <= w_last_byte;
                            r_m_eos   <= w_last_byte && w_last_line;
                            r_acc     <= '0;
                            r_lane    <= '0;
                            r_first   <= w_last_byte;
                        end else begin
                            r_acc  <= w_word;
                            r_lane <= r_lane + 2'd1;
                        end
                        if (w_last_byte) begin
                            r_chunk_cnt <= '0;
                            r_line      <= r_line + LineOne;
                        end else begin
                            r_chunk_cnt <= r_chunk_cnt + ChunkOne;
                        end
                    end
                    if (r_m_valid && m_ready && r_m_eos) begin
                        r_state <= StDone;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef DSC_BYTE_CNT_EN
    logic [31:0] r_byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
        end else if (start && (r_state == StIdle)) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
        end
    end

    assign byte_cnt = r_byte_cnt;
`endif

    assign busy    = (r_state != StIdle);
    assign err     = r_err;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_be    = r_m_be;
    assign m_sol   = r_m_sol;
    assign m_eol   = r_m_eol;
    assign m_eos   = r_m_eos;

endmodule
